reg_rw_axil_master: RTL and testbench
=====================================

REG_RW_AXIL_MASTER -- requirements
Module: reg_rw_axil_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, SHALL set the AXI4-Lite byte-address width; data is always 32 bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the watchdog limit (used only under REQ-040).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
REQ-004 Command-side ports SHALL be:
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  byte address.
- cmd_wdata_i  in  32  write data.
- cmd_wstrb_i  in  4  byte enables.
REQ-005 Response-side ports SHALL be:
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_we_o  out  1  echo of cmd_we_i.
- rsp_rdata_o  out  32  read data.
- rsp_resp_o  out  2  AXI response code.
REQ-006 AXI4-Lite manager write ports SHALL be:
- awaddr_o  out  ADDR_WIDTH.
- awvalid_o  out  1.
- awready_i  in  1.
- wdata_o  out  32.
- wstrb_o  out  4.
- wvalid_o  out  1.
- wready_i  in  1.
- bresp_i  in  2.
- bvalid_i  in  1.
- bready_o  out  1.
REQ-007 AXI4-Lite manager read ports SHALL be:
- araddr_o  out  ADDR_WIDTH.
- arvalid_o  out  1.
- arready_i  in  1.
- rdata_i  in  32.
- rresp_i  in  2.
- rvalid_i  in  1.
- rready_o  out  1.
REQ-008 The watchdog port timeout_o (out, 1) SHALL be a sticky flag indicating a handshake stall.

Function
REQ-010 The FSM SHALL have the states INIT, IDLE, WR_AW_W, WR_B, RD_AR, RD_R and RSP.
REQ-011 INIT SHALL last exactly 16 cycles, holding cmd_ready_o=0, then go to IDLE.
REQ-012 cmd_ready_o SHALL be 1 only in IDLE; a command is accepted on cmd_valid_i&cmd_ready_o.
REQ-013 On acceptance, the block SHALL register addr (bits [1:0] forced 0), wdata, wstrb and we, and go to WR_AW_W (we=1) or RD_AR (we=0).
REQ-014 awvalid_o and wvalid_o SHALL assert the cycle after acceptance, with payloads held stable while valid.
REQ-015 In WR_AW_W, awvalid_o SHALL drop the cycle after the awready_i handshake and wvalid_o the cycle after the wready_i handshake, independently.
- Handshake order is free: AW first, W first or simultaneous.
- The FSM SHALL enter WR_B once both handshakes are complete.
REQ-016 bready_o SHALL be 1 throughout WR_B.
- On bvalid_i, the block SHALL capture bresp_i into rsp_resp_o, set rsp_rdata_o=0 and go to RSP.
REQ-017 arvalid_o SHALL assert the cycle after a read is accepted and drop after the arready_i handshake.
- The FSM SHALL then go to RD_R.
REQ-018 rready_o SHALL be 1 throughout RD_R.
- On rvalid_i, the block SHALL capture rdata_i and rresp_i and go to RSP.
REQ-019 In RSP, rsp_valid_o SHALL be 1 with its payload stable until rsp_ready_i, then the FSM SHALL go to IDLE.
REQ-020 The block SHALL have at most one outstanding transaction, and SHALL never deassert a valid before its handshake.
REQ-021 Minimum command-to-response latency SHALL be 3 cycles for a read and 3 cycles for a write, assuming zero-wait subordinates.
REQ-022 A non-OKAY response (SLVERR, DECERR) SHALL be passed through unchanged; there is no retry.

Reset
REQ-030 rst_i SHALL force state INIT and clear the INIT counter.
REQ-031 rst_i SHALL zero every valid/ready output, rsp_* payload, timeout_o and the watchdog counter, all on the next clock edge.
REQ-032 A reset mid-transaction SHALL abandon the transaction silently, with no response issued.

Configuration
REQ-040 With AXIL_MASTER_TIMEOUT_EN defined, the watchdog SHALL be built as follows:
- A counter SHALL increment in WR_AW_W, WR_B, RD_AR and RD_R, and clear on every state change.
- When the counter reaches TIMEOUT_CYCLES-1, timeout_o SHALL set and stay set until reset.
- The AXI valids SHALL stay asserted and the FSM SHALL continue waiting.
REQ-041 Without the macro, timeout_o SHALL be tied 0 and no counter logic SHALL exist.

Structure
REQ-050 A shared package axil_pkg SHALL hold:
- the response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
- the FSM state enumeration;
- the INIT length constant (16).
REQ-051 The block SHALL be flat, with no sub-module.

Verification
REQ-060 Reset, then write 0x0000_1234 with addr 0x0408 and strb 0xF, against a zero-wait subordinate.
- The bench SHALL see awaddr_o=0x0408 and wdata_o=0x1234.
- The response SHALL be rsp_we_o=1 and rsp_resp_o=OKAY.
REQ-061 Write with wready_i 5 cycles ahead of awready_i, then again with the reverse order.
- Both cases SHALL produce exactly one B handshake and one response each.
REQ-062 Read of addr 0x0013 where the subordinate returns 0xDEADBEEF and SLVERR after 4 wait cycles.
- The bench SHALL see araddr_o=0x0010.
- The response SHALL be rsp_rdata_o=0xDEADBEEF and rsp_resp_o=2'b10.
REQ-063 cmd_valid_i held from the first cycle after reset.
- cmd_ready_o SHALL stay 0 for 16 cycles.
- Holding rsp_ready_i=0 for 10 cycles SHALL keep rsp_valid_o and its payload stable.
REQ-064 Assert rst_i while awvalid_o=1.
- All valids SHALL be 0 the next cycle.
- rsp_valid_o SHALL never assert, and a new command SHALL succeed after INIT.
REQ-065 Under AXIL_MASTER_TIMEOUT_EN, with TIMEOUT_CYCLES=8 and arready_i held 0:
- timeout_o SHALL set after 8 cycles in RD_AR, with arvalid_o still 1.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, manager FSM states and INIT length.
package axil_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int INIT_LEN = 16;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_t;

endpackage

// File: rtl/reg_rw_axil_master.sv
// Single-outstanding register read/write to AXI4-Lite manager bridge.
// Optional handshake watchdog built when AXIL_MASTER_TIMEOUT_EN is defined.
module reg_rw_axil_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]           cmd_wdata_i,
    input  logic [3:0]            cmd_wstrb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_we_o,
    output logic [31:0]           rsp_rdata_o,
    output logic [1:0]            rsp_resp_o,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [31:0]           wdata_o,
    output logic [3:0]            wstrb_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [31:0]           rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic                  timeout_o
);

    localparam int INIT_CNT_W = $clog2(INIT_LEN);

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [INIT_CNT_W-1:0]   r_initCnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wstrb;
    logic                    r_we;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_rspWe;
    logic [31:0]             r_rspRdata;
    logic [1:0]              r_rspResp;
    logic                    w_accept;
    logic                    w_initDone;
    logic                    w_awDone;
    logic                    w_wDone;

    assign w_accept   = cmd_valid_i && (r_state == IDLE);
    assign w_initDone = (r_initCnt == INIT_CNT_W'(INIT_LEN - 1));
    // A channel counts as done once its valid has dropped or is handshaking now.
    assign w_awDone   = !r_awvalid || awready_i;
    assign w_wDone    = !r_wvalid || wready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= INIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            INIT:    if (w_initDone) w_stateNext = IDLE;
            IDLE:    if (cmd_valid_i) w_stateNext = cmd_we_i ? WR_AW_W : RD_AR;
            WR_AW_W: if (w_awDone && w_wDone) w_stateNext = WR_B;
            WR_B:    if (bvalid_i) w_stateNext = RSP;
            RD_AR:   if (arready_i) w_stateNext = RD_R;
            RD_R:    if (rvalid_i) w_stateNext = RSP;
            RSP:     if (rsp_ready_i) w_stateNext = IDLE;
            default: w_stateNext = INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_initCnt  <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_we       <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_rspWe    <= 1'b0;
            r_rspRdata <= '0;
            r_rspResp  <= OKAY;
        end else begin
            r_initCnt <= (r_state == INIT) ? r_initCnt + INIT_CNT_W'(1) : '0;
            if (w_accept) begin
                r_addr    <= cmd_addr_i & ~ADDR_WIDTH'(3);
                r_wdata   <= cmd_wdata_i;
                r_wstrb   <= cmd_wstrb_i;
                r_we      <= cmd_we_i;
                r_awvalid <= cmd_we_i;
                r_wvalid  <= cmd_we_i;
            end
            if (r_awvalid && awready_i) r_awvalid <= 1'b0;
            if (r_wvalid && wready_i)   r_wvalid  <= 1'b0;
            if ((r_state == WR_B) && bvalid_i) begin
                r_rspWe    <= r_we;
                r_rspRdata <= '0;
                r_rspResp  <= bresp_i;
            end
            if ((r_state == RD_R) && rvalid_i) begin
                r_rspWe    <= r_we;
                r_rspRdata <= rdata_i;
                r_rspResp  <= rresp_i;
            end
        end
    end

    assign cmd_ready_o = (r_state == IDLE);
    assign rsp_valid_o = (r_state == RSP);
    assign rsp_we_o    = r_rspWe;
    assign rsp_rdata_o = r_rspRdata;
    assign rsp_resp_o  = r_rspResp;
    assign awaddr_o    = r_addr;
    assign awvalid_o   = r_awvalid;
    assign wdata_o     = r_wdata;
    assign wstrb_o     = r_wstrb;
    assign wvalid_o    = r_wvalid;
    assign bready_o    = (r_state == WR_B);
    assign araddr_o    = r_addr;
    assign arvalid_o   = (r_state == RD_AR);
    assign rready_o    = (r_state == RD_R);

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] r_wdCnt;
    logic            r_timeout;
    logic            w_waiting;
    logic            w_wdLimit;

    assign w_waiting = (r_state == WR_AW_W) || (r_state == WR_B) ||
                       (r_state == RD_AR) || (r_state == RD_R);
    assign w_wdLimit = (r_wdCnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Counter saturates at the limit; the flag only flags the stall, the FSM keeps waiting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wdCnt   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_stateNext != r_state) begin
                r_wdCnt <= '0;
            end else if (w_waiting && !w_wdLimit) begin
                r_wdCnt <= r_wdCnt + WD_W'(1);
            end
            if (w_waiting && w_wdLimit) r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;
`else
    logic w_unusedTimeout;
    assign w_unusedTimeout = (TIMEOUT_CYCLES > 0);
    assign timeout_o       = 1'b0;
`endif

endmodule

// File: tb/tb_reg_rw_axil_master.sv
// Self-checking bench for reg_rw_axil_master with a delay-configurable AXI4-Lite subordinate.
// Define AXIL_MASTER_TIMEOUT_EN to also exercise the watchdog.
module tb_reg_rw_axil_master;
    import axil_pkg::*;

    localparam int ADDR_WIDTH     = 16;
    localparam int TIMEOUT_CYCLES = 8;
`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                  clk_i;
    logic                  rst_i;
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [31:0]           cmd_wdata_i;
    logic [3:0]            cmd_wstrb_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic                  rsp_we_o;
    logic [31:0]           rsp_rdata_o;
    logic [1:0]            rsp_resp_o;
    logic [ADDR_WIDTH-1:0] awaddr_o;
    logic                  awvalid_o;
    logic                  awready_i;
    logic [31:0]           wdata_o;
    logic [3:0]            wstrb_o;
    logic                  wvalid_o;
    logic                  wready_i;
    logic [1:0]            bresp_i;
    logic                  bvalid_i;
    logic                  bready_o;
    logic [ADDR_WIDTH-1:0] araddr_o;
    logic                  arvalid_o;
    logic                  arready_i;
    logic [31:0]           rdata_i;
    logic [1:0]            rresp_i;
    logic                  rvalid_i;
    logic                  rready_o;
    logic                  timeout_o;

    int checkCount = 0;
    int errorCount = 0;

    int                    cfgAwDelay, cfgWDelay, cfgBDelay, cfgArDelay, cfgRDelay;
    logic [1:0]            cfgBResp, cfgRResp;
    logic [31:0]           cfgRData;
    int                    awCount, wCount, bCount, arCount, rCount;
    logic [ADDR_WIDTH-1:0] gotAwaddr, gotAraddr;
    logic [31:0]           gotWdata;
    logic [3:0]            gotWstrb;

    reg_rw_axil_master #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .cmd_wstrb_i (cmd_wstrb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_we_o    (rsp_we_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_resp_o  (rsp_resp_o),
        .awaddr_o    (awaddr_o),
        .awvalid_o   (awvalid_o),
        .awready_i   (awready_i),
        .wdata_o     (wdata_o),
        .wstrb_o     (wstrb_o),
        .wvalid_o    (wvalid_o),
        .wready_i    (wready_i),
        .bresp_i     (bresp_i),
        .bvalid_i    (bvalid_i),
        .bready_o    (bready_o),
        .araddr_o    (araddr_o),
        .arvalid_o   (arvalid_o),
        .arready_i   (arready_i),
        .rdata_i     (rdata_i),
        .rresp_i     (rresp_i),
        .rvalid_i    (rvalid_i),
        .rready_o    (rready_o),
        .timeout_o   (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setDelays(input int aw, input int w, input int b, input int ar, input int r);
        cfgAwDelay = aw;
        cfgWDelay  = w;
        cfgBDelay  = b;
        cfgArDelay = ar;
        cfgRDelay  = r;
    endtask

    // Subordinate model: each channel waits its configured cycles once the request is visible.
    // Readies/valids change on negedges, so a grant made here handshakes on the next posedge.
    initial begin : subordinate
        int awWait, wWait, bWait, arWait, rWait;
        bit awGot, wGot, bPending, rPending, bHsNext, rHsNext;
        awWait = 0; wWait = 0; bWait = 0; arWait = 0; rWait = 0;
        awGot = 0; wGot = 0; bPending = 0; rPending = 0; bHsNext = 0; rHsNext = 0;
        awCount = 0; wCount = 0; bCount = 0; arCount = 0; rCount = 0;
        gotAwaddr = '0; gotAraddr = '0; gotWdata = '0; gotWstrb = '0;
        awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
        arready_i = 0; rvalid_i = 0; rresp_i = 0; rdata_i = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                awWait = 0; wWait = 0; bWait = 0; arWait = 0; rWait = 0;
                awGot = 0; wGot = 0; bPending = 0; rPending = 0; bHsNext = 0; rHsNext = 0;
                awready_i = 0; wready_i = 0; bvalid_i = 0; arready_i = 0; rvalid_i = 0;
            end else begin
                if (bHsNext) begin bvalid_i = 0; bHsNext = 0; end
                if (bPending) begin
                    if (bWait >= cfgBDelay) begin
                        bvalid_i = 1;
                        bresp_i  = cfgBResp;
                        if (bready_o) begin bHsNext = 1; bPending = 0; bCount++; end
                    end else bWait++;
                end
                if (rHsNext) begin rvalid_i = 0; rHsNext = 0; end
                if (rPending) begin
                    if (rWait >= cfgRDelay) begin
                        rvalid_i = 1;
                        rdata_i  = cfgRData;
                        rresp_i  = cfgRResp;
                        if (rready_o) begin rHsNext = 1; rPending = 0; rCount++; end
                    end else rWait++;
                end
                awready_i = 0;
                if (awvalid_o) begin
                    if (awWait >= cfgAwDelay) begin
                        awready_i = 1; awCount++; gotAwaddr = awaddr_o; awGot = 1; awWait = 0;
                    end else awWait++;
                end else awWait = 0;
                wready_i = 0;
                if (wvalid_o) begin
                    if (wWait >= cfgWDelay) begin
                        wready_i = 1; wCount++; gotWdata = wdata_o; gotWstrb = wstrb_o; wGot = 1; wWait = 0;
                    end else wWait++;
                end else wWait = 0;
                if (awGot && wGot) begin bPending = 1; bWait = 0; awGot = 0; wGot = 0; end
                arready_i = 0;
                if (arvalid_o) begin
                    if (arWait >= cfgArDelay) begin
                        arready_i = 1; arCount++; gotAraddr = araddr_o; rPending = 1; rWait = 0; arWait = 0;
                    end else arWait++;
                end else arWait = 0;
            end
        end
    end

    // One full command/response transaction, checked against the expected outcome.
    // Called on a negedge; returns on a negedge with the DUT back in IDLE.
    task automatic applyStimulus(input bit we, input logic [ADDR_WIDTH-1:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input logic [1:0] resp, input logic [31:0] rdata,
                                 input int hold, output int readyWait);
        logic [ADDR_WIDTH-1:0] expAddr;
        logic [31:0]           expRdata;
        int expLat, lat, stable, waited, stray;
        int aw0, w0, b0, ar0, r0;
        expAddr  = ADDR_WIDTH'((int'(addr) / 4) * 4);
        expRdata = we ? 32'h0 : rdata;
        expLat   = we ? 3 + ((cfgAwDelay > cfgWDelay) ? cfgAwDelay : cfgWDelay) + cfgBDelay
                      : 3 + cfgArDelay + cfgRDelay;
        cfgBResp = resp;
        cfgRResp = resp;
        cfgRData = rdata;
        aw0 = awCount; w0 = wCount; b0 = bCount; ar0 = arCount; r0 = rCount;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_wstrb_i = strb;
        cmd_valid_i = 1;
        waited = 0;
        stray  = 0;
        while (!cmd_ready_o && waited < 100) begin
            if (rsp_valid_o) stray++;
            waited++;
            @(negedge clk_i);
        end
        readyWait = waited;
        checkOutput("cmdAccepted", 64'(cmd_ready_o), 64'(1));
        checkOutput("strayRsp", 64'(stray), 64'(0));
        @(negedge clk_i);
        cmd_valid_i = 0;
        checkOutput("reqValids", 64'({awvalid_o, wvalid_o, arvalid_o}), 64'({we, we, !we}));
        lat = 1;
        while (!rsp_valid_o && lat < 200) begin
            @(negedge clk_i);
            lat++;
        end
        checkOutput("rspValid", 64'(rsp_valid_o), 64'(1));
        checkOutput("latency", 64'(lat), 64'(expLat));
        checkOutput("rspPayload", 64'({rsp_we_o, rsp_rdata_o, rsp_resp_o}), 64'({we, expRdata, resp}));
        stable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o && ({rsp_we_o, rsp_rdata_o, rsp_resp_o} === {we, expRdata, resp})) stable++;
        end
        checkOutput("rspHold", 64'(stable), 64'(hold));
        rsp_ready_i = 1;
        @(negedge clk_i);
        rsp_ready_i = 0;
        checkOutput("rspRetired", 64'(rsp_valid_o), 64'(0));
        checkOutput("hsCounts",
                    64'({4'(awCount - aw0), 4'(wCount - w0), 4'(bCount - b0), 4'(arCount - ar0), 4'(rCount - r0)}),
                    64'({4'(we), 4'(we), 4'(we), 4'(!we), 4'(!we)}));
        if (we) checkOutput("wrPayload", 64'({gotAwaddr, gotWdata, gotWstrb}), 64'({expAddr, wdata, strb}));
        else    checkOutput("araddr", 64'(gotAraddr), 64'(expAddr));
    endtask

    initial begin : stimulus
        int readyWait, waited, lat;
        logic t8, t9, ar9;
        rst_i       = 1;
        cmd_valid_i = 0;
        cmd_we_i    = 0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        cmd_wstrb_i = '0;
        rsp_ready_i = 0;
        cfgBResp    = OKAY;
        cfgRResp    = OKAY;
        cfgRData    = '0;
        setDelays(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk_i);
        checkOutput("rstReady", 64'(cmd_ready_o), 64'(0));
        checkOutput("rstValids", 64'({awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}), 64'(0));
        checkOutput("rstPayload", 64'({rsp_we_o, rsp_rdata_o, rsp_resp_o}), 64'(0));
        checkOutput("rstTimeout", 64'(timeout_o), 64'(0));

        $display("[TB] zero-wait write held from reset, response held 10 cycles");
        rst_i = 0;
        applyStimulus(1, 16'h0408, 32'h0000_1234, 4'hF, OKAY, 32'h0, 10, readyWait);
        checkOutput("initReadyWait", 64'(readyWait), 64'(16));
        checkOutput("firstWrite", 64'({gotAwaddr, gotWdata}), 64'({16'h0408, 32'h0000_1234}));

        $display("[TB] W ahead of AW, then AW ahead of W");
        setDelays(5, 0, 0, 0, 0);
        applyStimulus(1, 16'h1100, $urandom, 4'h3, OKAY, 32'h0, 0, readyWait);
        setDelays(0, 5, 0, 0, 0);
        applyStimulus(1, 16'h2202, $urandom, 4'hC, DECERR, 32'h0, 1, readyWait);

        $display("[TB] slow read with SLVERR");
        setDelays(0, 0, 0, 0, 4);
        applyStimulus(0, 16'h0013, 32'h0, 4'h0, SLVERR, 32'hDEADBEEF, 2, readyWait);
        checkOutput("slowReadAddr", 64'(gotAraddr), 64'(16'h0010));

        $display("[TB] randomized transactions");
        for (int n = 0; n < 8; n++) begin
            setDelays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3), readyWait);
        end

        $display("[TB] reset while AW is pending");
        setDelays(20, 20, 0, 0, 0);
        cmd_we_i    = 1;
        cmd_addr_i  = 16'h0A0C;
        cmd_wdata_i = 32'hCAFE_0001;
        cmd_wstrb_i = 4'hF;
        cmd_valid_i = 1;
        waited = 0;
        while (!cmd_ready_o && waited < 100) begin
            waited++;
            @(negedge clk_i);
        end
        @(negedge clk_i);
        cmd_valid_i = 0;
        checkOutput("midAwvalid", 64'(awvalid_o), 64'(1));
        rst_i = 1;
        @(negedge clk_i);
        checkOutput("midRstValids",
                    64'({cmd_ready_o, awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}), 64'(0));
        @(negedge clk_i);
        rst_i = 0;
        setDelays(0, 0, 0, 0, 0);
        applyStimulus(0, 16'h0ABC, 32'h0, 4'h0, OKAY, $urandom, 0, readyWait);
        checkOutput("postRstReadyWait", 64'(readyWait), 64'(16));

        $display("[TB] AR stalled past the watchdog limit");
        setDelays(0, 0, 0, 12, 0);
        cfgRResp    = OKAY;
        cfgRData    = 32'h0BAD_F00D;
        cmd_we_i    = 0;
        cmd_addr_i  = 16'h0044;
        cmd_valid_i = 1;
        waited = 0;
        while (!cmd_ready_o && waited < 100) begin
            waited++;
            @(negedge clk_i);
        end
        @(negedge clk_i);
        cmd_valid_i = 0;
        t8 = 0; t9 = 0; ar9 = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 8) t8 = timeout_o;
            if (k == 9) begin t9 = timeout_o; ar9 = arvalid_o; end
            if (k < 9) @(negedge clk_i);
        end
        checkOutput("watchdog", 64'({t8, t9, ar9}), 64'({1'b0, TO_EN, 1'b1}));
        lat = 0;
        while (!rsp_valid_o && lat < 200) begin
            @(negedge clk_i);
            lat++;
        end
        checkOutput("stallRsp", 64'({rsp_valid_o, rsp_rdata_o}), 64'({1'b1, 32'h0BAD_F00D}));
        rsp_ready_i = 1;
        @(negedge clk_i);
        rsp_ready_i = 0;
        checkOutput("timeoutSticky", 64'({cmd_ready_o, timeout_o}), 64'({1'b1, TO_EN}));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
